// File: rtl/filter_pkg.sv
// Shared types and pipeline offsets for the median-filter scan controller.
package filter_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  // Read strobe to RAM data valid, and read strobe to fifo1 write strobe.
  localparam int unsigned RAM_LAT    = 1;
  localparam int unsigned FIFO1_OFS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/filter_scan_controller_valid_delay.sv
// Fixed-length shift line carrying a strobe and its address.
module valid_delay #(
  parameter int unsigned LEN    = 1,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr
);

  logic [LEN-1:0]    r_vld;
  logic [ADDR_W-1:0] r_addr [LEN];

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_vld <= '0;
      for (int i = 0; i < LEN; i++) r_addr[i] <= '0;
    end else begin
      for (int i = LEN - 1; i > 0; i--) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
      r_vld[0]  <= i_vld;
      r_addr[0] <= i_addr;
    end
  end

  assign o_vld  = r_vld[LEN-1];
  assign o_addr = r_addr[LEN-1];

endmodule

// File: rtl/filter_scan_controller.sv
// Raster-scan sequencer for a 3x3 median filter: reads every pixel once,
// drives the two line buffers and sorter, and writes back interior medians.
module filter_scan_controller
  import filter_pkg::*;
#(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned SORT_LAT = 1
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              fifo1_wr_en,
  output logic              fifo1_rd_en,
  output logic              fifo2_wr_en,
  output logic              fifo2_rd_en,
  output logic              sort_en
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] CTR_OFS     = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] COL_LAST    = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] FIFO_RD_MIN = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] WIN_MIN     = ADDR_W'(2);

  if ((64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_W)) || (IMG_W < 4) || (IMG_H < 3) ||
      (SORT_LAT < 1)) begin : g_param_chk
    $error("filter_scan_controller: illegal image geometry or latency");
  end

  state_e            r_state, w_state_nxt;
  logic              r_busy, r_done, r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              w_ram_vld;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [ADDR_W-1:0] r_col, r_row;
  logic              r_sort_en;
  logic [ADDR_W-1:0] r_sort_addr;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] r_wr_pend, w_wr_pend_nxt;
  logic              w_pending;
  logic              w_f1_vld, w_f2_vld;
  logic [ADDR_W-1:0] w_f1_addr, w_f2_addr, r_f1_addr;
  logic              r_f1_wr, r_f1_rd, r_f2_wr, r_f2_rd;

  // Writes issued by the sorter but not yet strobed out, as of next cycle.
  assign w_wr_pend_nxt = r_wr_pend + ADDR_W'(r_sort_en) - ADDR_W'(w_wr_en);
  assign w_pending     = w_ram_vld | r_sort_en | (w_wr_pend_nxt != '0);

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_READ;
      ST_READ:   if (r_rd_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!w_pending) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_pend <= '0;
    end else begin
      r_busy    <= (w_state_nxt == ST_READ) || (w_state_nxt == ST_DRAIN);
      r_done    <= (w_state_nxt == ST_FINISH);
      r_rd_en   <= (w_state_nxt == ST_READ);
      r_rd_addr <= ((r_state == ST_READ) && (w_state_nxt == ST_READ)) ?
                   r_rd_addr + ADDR_W'(1) : '0;
      r_wr_pend <= w_wr_pend_nxt;
    end
  end

  valid_delay #(.LEN(RAM_LAT), .ADDR_W(ADDR_W)) u_ram_dly (
    .clk(clk), .nres(nres), .i_vld(r_rd_en), .i_addr(r_rd_addr),
    .o_vld(w_ram_vld), .o_addr(w_ram_addr)
  );

  // Counters hold the raster position of the pixel entering the first tap.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_col       <= '0;
      r_row       <= '0;
      r_sort_en   <= 1'b0;
      r_sort_addr <= '0;
    end else begin
      r_sort_en   <= w_ram_vld && (r_row >= WIN_MIN) && (r_col >= WIN_MIN);
      r_sort_addr <= w_ram_addr - CTR_OFS;
      if (r_state == ST_IDLE) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_ram_vld) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + ADDR_W'(1);
        end else begin
          r_col <= r_col + ADDR_W'(1);
        end
      end
    end
  end

  valid_delay #(.LEN(SORT_LAT), .ADDR_W(ADDR_W)) u_wr_dly (
    .clk(clk), .nres(nres), .i_vld(r_sort_en), .i_addr(r_sort_addr),
    .o_vld(w_wr_en), .o_addr(w_wr_addr)
  );

  valid_delay #(.LEN(FIFO1_OFS - 1), .ADDR_W(ADDR_W)) u_f1_dly (
    .clk(clk), .nres(nres), .i_vld(r_rd_en), .i_addr(r_rd_addr),
    .o_vld(w_f1_vld), .o_addr(w_f1_addr)
  );

  valid_delay #(.LEN(IMG_W - 1), .ADDR_W(ADDR_W)) u_f2_dly (
    .clk(clk), .nres(nres), .i_vld(r_f1_wr), .i_addr(r_f1_addr),
    .o_vld(w_f2_vld), .o_addr(w_f2_addr)
  );

  // Pixel index j equals the number of earlier fifo writes in this pass.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_f1_wr   <= 1'b0;
      r_f1_rd   <= 1'b0;
      r_f1_addr <= '0;
      r_f2_wr   <= 1'b0;
      r_f2_rd   <= 1'b0;
    end else begin
      r_f1_wr   <= w_f1_vld;
      r_f1_rd   <= w_f1_vld && (w_f1_addr >= FIFO_RD_MIN);
      r_f1_addr <= w_f1_addr;
      r_f2_wr   <= w_f2_vld;
      r_f2_rd   <= w_f2_vld && (w_f2_addr >= FIFO_RD_MIN);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign ram_rd_en   = r_rd_en;
  assign ram_rd_addr = r_rd_addr;
  assign ram_wr_en   = w_wr_en;
  assign ram_wr_addr = w_wr_addr;
  assign fifo1_wr_en = r_f1_wr;
  assign fifo1_rd_en = r_f1_rd;
  assign fifo2_wr_en = r_f2_wr;
  assign fifo2_rd_en = r_f2_rd;
  assign sort_en     = r_sort_en;

endmodule
